// File: rtl/edsac_tank_pkg.sv
// Shared constants and types for the mercury-tank store family.
// Counter widths are fixed at 5 bits so every tank presents the same digit/word ports.
package edsac_tank_pkg;

  localparam int WORD_BITS_DEF = 18;
  localparam int WORDS_DEF     = 32;
  localparam int LINE_BITS_DEF = WORD_BITS_DEF * WORDS_DEF;
  localparam int DIGIT_W       = 5;
  localparam int WORD_W        = 5;

  typedef struct packed {
    logic [WORD_W-1:0]  word;
    logic [DIGIT_W-1:0] digit;
  } tank_pos_t;

  // Recirculation gate: clear removes the old bit, write ORs a one in.
  function automatic logic gate_bit(input logic e, input logic t_in, input logic t_clr);
    return (~t_clr & e) | t_in;
  endfunction

endpackage

// File: rtl/tank_timing.sv
// Digit/word position counter for one tank, plus the registered revolution sync.
// pos names the slot whose bit exits on the current adv; it steps on that same edge.
module tank_timing
  import edsac_tank_pkg::*;
#(
  parameter int WORD_BITS = WORD_BITS_DEF,
  parameter int WORDS     = WORDS_DEF
) (
  input  logic      clk,
  input  logic      cls_neg,
  input  logic      adv,
  output tank_pos_t pos,
  output logic      word_end,
  output logic      sync
);

  localparam logic [DIGIT_W-1:0] DIGIT_LAST = DIGIT_W'(WORD_BITS - 1);
  localparam logic [WORD_W-1:0]  WORD_LAST  = WORD_W'(WORDS - 1);

  logic line_start;

  assign word_end   = (pos.digit == DIGIT_LAST);
  assign line_start = (pos.digit == '0) && (pos.word == '0);

  always_ff @(posedge clk or negedge cls_neg) begin
    if (!cls_neg) begin
      pos  <= '0;
      sync <= 1'b0;
    end else begin
      sync <= adv & line_start;
      if (adv) begin
        if (word_end) begin
          pos.digit <= '0;
          pos.word  <= (pos.word == WORD_LAST) ? '0 : pos.word + 1'b1;
        end else begin
          pos.digit <= pos.digit + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tank_store_f1.sv
// One recirculating delay-line tank: gated shift line, registered output bit,
// and a word assembler that publishes each complete word as it leaves the line.
module tank_store_f1
  import edsac_tank_pkg::*;
#(
  parameter int WORD_BITS = WORD_BITS_DEF,
  parameter int WORDS     = WORDS_DEF,
  parameter int LINE_BITS = WORD_BITS * WORDS
) (
  input  logic                 clk,
  input  logic                 cls_neg,
  input  logic                 adv,
  input  logic                 t_in,
  input  logic                 t_clr,
  output logic                 mob_t,
  output logic [DIGIT_W-1:0]   digit,
  output logic [WORD_W-1:0]    word,
  output logic                 sync,
  output logic [WORD_BITS-1:0] word_q,
  output logic                 word_q_vld,
  output logic [WORD_W-1:0]    word_q_addr
);

  tank_pos_t pos;
  logic      word_end;

  tank_timing #(
    .WORD_BITS (WORD_BITS),
    .WORDS     (WORDS)
  ) u_timing (
    .clk      (clk),
    .cls_neg  (cls_neg),
    .adv      (adv),
    .pos      (pos),
    .word_end (word_end),
    .sync     (sync)
  );

  assign digit = pos.digit;
  assign word  = pos.word;

  logic [LINE_BITS-1:0] line_q;
  logic                 e;
  logic                 ins;

  assign e   = line_q[LINE_BITS-1];
  assign ins = gate_bit(e, t_in, t_clr);

  always_ff @(posedge clk or negedge cls_neg) begin
    if (!cls_neg) line_q <= '0;
    else if (adv) line_q <= {line_q[LINE_BITS-2:0], ins};
  end

  // Assembler image including the bit exiting now, so the last digit lands in word_q.
  logic [WORD_BITS-1:0] asm_q;
  logic [WORD_BITS-1:0] asm_nxt;

  always_comb begin
    asm_nxt            = asm_q;
    asm_nxt[pos.digit] = e;
  end

  always_ff @(posedge clk or negedge cls_neg) begin
    if (!cls_neg) begin
      mob_t       <= 1'b0;
      asm_q       <= '0;
      word_q      <= '0;
      word_q_vld  <= 1'b0;
      word_q_addr <= '0;
    end else begin
      word_q_vld <= 1'b0;
      if (adv) begin
        mob_t <= e;
        asm_q <= asm_nxt;
        if (word_end) begin
          word_q      <= asm_nxt;
          word_q_addr <= pos.word;
          word_q_vld  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tank_store_f1.sv
// Randomized bench for tank_store_f1 against a slot-array model of the tank.
// The model indexes 576 bit slots by revolution position and derives every output from that.
module tb_tank_store_f1;

  localparam int WB = 18;
  localparam int NW = 32;
  localparam int LB = WB * NW;

  logic          clk = 1'b0;
  logic          cls_neg = 1'b0;
  logic          adv = 1'b0;
  logic          t_in = 1'b0;
  logic          t_clr = 1'b0;
  logic          mob_t;
  logic [4:0]    digit;
  logic [4:0]    word;
  logic          sync;
  logic [WB-1:0] word_q;
  logic          word_q_vld;
  logic [4:0]    word_q_addr;

  tank_store_f1 dut (
    .clk         (clk),
    .cls_neg     (cls_neg),
    .adv         (adv),
    .t_in        (t_in),
    .t_clr       (t_clr),
    .mob_t       (mob_t),
    .digit       (digit),
    .word        (word),
    .sync        (sync),
    .word_q      (word_q),
    .word_q_vld  (word_q_vld),
    .word_q_addr (word_q_addr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: slot contents by position, current position, expected outputs.
  bit            mem [LB];
  int            pos;
  logic          exp_mob, exp_sync, exp_vld;
  logic [WB-1:0] exp_wq, acc;
  logic [4:0]    exp_addr, exp_digit, exp_word;

  task automatic model_reset();
    for (int i = 0; i < LB; i++) mem[i] = 1'b0;
    pos = 0; acc = '0;
    exp_mob = 0; exp_sync = 0; exp_vld = 0; exp_wq = '0; exp_addr = '0;
    exp_digit = '0; exp_word = '0;
  endtask

  task automatic step(input logic a, input logic ti, input logic tc);
    bit e;
    adv = a; t_in = ti; t_clr = tc;
    @(posedge clk);
    if (a) begin
      e = mem[pos];
      mem[pos] = (e & ~tc) | ti;
      exp_mob  = e;
      acc[pos % WB] = e;
      exp_sync = (pos == 0);
      exp_vld  = ((pos % WB) == WB - 1);
      if (exp_vld) begin
        exp_wq   = acc;
        exp_addr = 5'(pos / WB);
      end
      pos = (pos + 1) % LB;
    end else begin
      exp_sync = 1'b0;
      exp_vld  = 1'b0;
    end
    exp_digit = 5'(pos % WB);
    exp_word  = 5'(pos / WB);
    #1;
  endtask

  task automatic goto_pos(input int target);
    for (int k = 0; k < LB && pos != target; k++) step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic write_word(input int w, input logic [WB-1:0] val, input logic clr);
    goto_pos(w * WB);
    for (int i = 0; i < WB; i++) step(1'b1, val[i], clr);
  endtask

  task automatic read_word(input int w);
    goto_pos(w * WB);
    for (int i = 0; i < WB; i++) step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    cls_neg = 1'b0;
    #1;
    model_reset();
    total++;
    if ({mob_t, sync, digit, word, word_q, word_q_vld, word_q_addr} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got mob=%0b sync=%0b d=%0d w=%0d wq=%0h vld=%0b addr=%0d exp all zero",
               mob_t, sync, digit, word, word_q, word_q_vld, word_q_addr);
    end
    @(negedge clk);
    cls_neg = 1'b1;
  endtask

  task automatic test_idle_rev();
    int nsync = 0, nvld = 0, nz = 0, nmob = 0, npos = 0;
    step(1'b1, 1'b0, 1'b0);
    total++;
    if (sync !== 1'b1) begin bad++; $display("FAIL first_adv_sync got=%0b exp=1", sync); end
    nsync++;
    for (int i = 1; i < LB; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (sync) nsync++;
      if (mob_t !== 1'b0) nmob++;
      if (word_q_vld) begin nvld++; if (word_q !== '0) nz++; end
      if (digit !== exp_digit || word !== exp_word) npos++;
    end
    total++; if (nsync != 1)  begin bad++; $display("FAIL idle_sync_count got=%0d exp=1", nsync); end
    total++; if (nvld != 32)  begin bad++; $display("FAIL idle_vld_count got=%0d exp=32", nvld); end
    total++; if (nz != 0)     begin bad++; $display("FAIL idle_word_q_nonzero got=%0d exp=0", nz); end
    total++; if (nmob != 0)   begin bad++; $display("FAIL idle_mob_t_ones got=%0d exp=0", nmob); end
    total++; if (npos != 0)   begin bad++; $display("FAIL idle_position got=%0d bad steps exp=0", npos); end
  endtask

  task automatic test_write_pattern();
    write_word(5, 18'h2AAAA, 1'b1);
    read_word(5);
    total++;
    if (word_q_vld !== 1'b1 || word_q !== 18'h2AAAA || word_q_addr !== 5'd5) begin
      bad++;
      $display("FAIL pattern_word5 got vld=%0b wq=%0h addr=%0d exp vld=1 wq=2aaaa addr=5",
               word_q_vld, word_q, word_q_addr);
    end
  endtask

  task automatic test_or_clear();
    write_word(7, 18'h3FFFF, 1'b1);
    write_word(7, 18'h00001, 1'b0);
    read_word(7);
    total++;
    if (word_q !== 18'h3FFFF || word_q_addr !== 5'd7 || word_q_vld !== 1'b1) begin
      bad++; $display("FAIL or_write got wq=%0h addr=%0d exp wq=3ffff addr=7", word_q, word_q_addr);
    end
    write_word(7, 18'h00001, 1'b1);
    read_word(7);
    total++;
    if (word_q !== 18'h00001 || word_q_addr !== 5'd7 || word_q_vld !== 1'b1) begin
      bad++; $display("FAIL clear_write got wq=%0h addr=%0d exp wq=00001 addr=7", word_q, word_q_addr);
    end
  endtask

  // Random adv gaps with random writes, then a gapped readback, then a continuous one.
  task automatic test_gaps();
    for (int rev = 0; rev < 3; rev++) begin
      int cnt = 0;
      for (int guard = 0; guard < 20000 && cnt < LB; guard++) begin
        logic a, ti, tc;
        a  = (rev == 2) ? 1'b1 : ($urandom_range(0, 99) < 30);
        ti = (rev == 0) ? 1'($urandom_range(0, 1)) : (a ? 1'b0 : 1'($urandom_range(0, 1)));
        tc = (rev == 0) ? 1'($urandom_range(0, 1)) : (a ? 1'b0 : 1'($urandom_range(0, 1)));
        step(a, ti, tc);
        if (a) cnt++;
        total++;
        if (mob_t !== exp_mob || sync !== exp_sync || digit !== exp_digit || word !== exp_word ||
            word_q_vld !== exp_vld || (exp_vld && (word_q !== exp_wq || word_q_addr !== exp_addr))) begin
          bad++;
          $display("FAIL gaps_rev%0d got mob=%0b sync=%0b d=%0d w=%0d vld=%0b wq=%0h addr=%0d exp mob=%0b sync=%0b d=%0d w=%0d vld=%0b wq=%0h addr=%0d",
                   rev, mob_t, sync, digit, word, word_q_vld, word_q, word_q_addr,
                   exp_mob, exp_sync, exp_digit, exp_word, exp_vld, exp_wq, exp_addr);
        end
      end
      total++;
      if (cnt != LB) begin bad++; $display("FAIL gaps_budget got=%0d advs exp=%0d", cnt, LB); end
    end
  endtask

  task automatic test_reset_mid();
    int nvld = 0, nbad = 0;
    goto_pos(0);
    for (int i = 0; i < LB; i++) step(1'b1, 1'b1, 1'b0);
    goto_pos(12 * WB + 9);
    test_reset();
    for (int i = 0; i < LB; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (i == 0) begin
        total++;
        if (sync !== 1'b1) begin bad++; $display("FAIL post_reset_sync got=%0b exp=1", sync); end
      end
      if (word_q_vld) begin
        if (word_q !== '0 || word_q_addr !== 5'(nvld)) nbad++;
        nvld++;
      end
    end
    total++; if (nvld != 32) begin bad++; $display("FAIL reset_mid_vld_count got=%0d exp=32", nvld); end
    total++; if (nbad != 0)  begin bad++; $display("FAIL reset_mid_words got=%0d bad words exp=0", nbad); end
  endtask

  task automatic test_sync_period();
    int nsync = 0, last = -1, ngap = 0, nwrap = 0, nwbad = 0;
    logic [4:0] pd, pw;
    goto_pos(0);
    pd = digit; pw = word;
    for (int n = 1; n <= 3 * LB; n++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (sync) begin
        if (last >= 0 && n - last != LB) ngap++;
        last = n; nsync++;
      end
      if (pw == 5'd31 && word == 5'd0) begin
        nwrap++;
        if (pd != 5'd17 || digit != 5'd0) nwbad++;
      end else if (word != pw && pd != 5'd17) nwbad++;
      pd = digit; pw = word;
    end
    total++; if (nsync != 3) begin bad++; $display("FAIL sync_count got=%0d exp=3", nsync); end
    total++; if (ngap != 0)  begin bad++; $display("FAIL sync_period got=%0d bad gaps exp=0", ngap); end
    total++; if (nwrap != 3) begin bad++; $display("FAIL word_wrap_count got=%0d exp=3", nwrap); end
    total++; if (nwbad != 0) begin bad++; $display("FAIL word_wrap_align got=%0d exp=0", nwbad); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_idle_rev();
    test_write_pattern();
    test_or_clear();
    test_gaps();
    test_reset_mid();
    test_sync_period();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
